// File: rtl/lcd_fifo_pkg.sv
// Shared definitions for the LCD command path FIFOs.
//   CMD_WIDTH      : width of one {dc, byte} command word.
//   ptr_width()    : width of a FIFO pointer / level for a given depth.
//                    One extra bit beyond the index lets full and empty be told apart.
package lcd_fifo_pkg;

  localparam int CMD_WIDTH = 9;

  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage array for stream_fifo.
// One synchronous write port and one asynchronous read port. The array is not reset.
// Ports:
//   clk         : clock
//   write_en    : store write_data at write_addr on the rising edge
//   write_addr  : write index
//   write_data  : word to store
//   read_addr   : read index
//   read_data   : word at read_addr (combinational)
module fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             write_en,
  input  logic [AW-1:0]    write_addr,
  input  logic [WIDTH-1:0] write_data,
  input  logic [AW-1:0]    read_addr,
  output logic [WIDTH-1:0] read_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[write_addr] <= write_data;
    end
  end

  assign read_data = mem[read_addr];

endmodule

// File: rtl/stream_fifo.sv
// Valid/ready FIFO between the command sequencer and the SPI LCD serialiser.
// Supports registered or first-word-fall-through reads, occupancy level,
// almost-full/almost-empty flags, synchronous flush and a high-water mark.
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   flush                     : synchronous clear of contents (wins over read/write)
//   hwm_clr                   : load max_level with the current level
//   write_valid/ready/data    : producer side
//   read_valid/ready/data     : consumer side
//   level                     : occupancy 0..DEPTH
//   max_level                 : highest level since reset, flush or hwm_clr
//   almost_full, almost_empty : threshold flags decoded from level
module stream_fifo
  import lcd_fifo_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int WIDTH         = CMD_WIDTH,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         hwm_clr,
  input  logic                         write_valid,
  output logic                         write_ready,
  input  logic [WIDTH-1:0]             write_data,
  output logic                         read_valid,
  input  logic                         read_ready,
  output logic [WIDTH-1:0]             read_data,
  output logic [ptr_width(DEPTH)-1:0]  level,
  output logic [ptr_width(DEPTH)-1:0]  max_level,
  output logic                         almost_full,
  output logic                         almost_empty
);

  localparam int LW = ptr_width(DEPTH);
  localparam int AW = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [LW-1:0] AF_LEVEL   = LW'(AFULL_THRESH);
  localparam logic [LW-1:0] AE_LEVEL   = LW'(AEMPTY_THRESH);

  logic [LW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    wr_ptr_nxt, rd_ptr_nxt, level_nxt;
  logic             wr_fire, rd_fire;
  logic [WIDTH-1:0] head_data;

  // Handshake flags come only from the registered pointers, never from the
  // opposite side's valid/ready, so there is no bypass when full or empty.
  assign level        = wr_ptr - rd_ptr;
  assign write_ready  = (level != FULL_LEVEL);
  assign read_valid   = (level != '0);
  assign almost_full  = (level >= AF_LEVEL);
  assign almost_empty = (level <= AE_LEVEL);

  // A flush discards any same-cycle transfer on either side.
  assign wr_fire = write_valid & write_ready & ~flush;
  assign rd_fire = read_valid & read_ready & ~flush;

  // Next pointer values; the next level feeds the high-water mark.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
    end else begin
      if (wr_fire) wr_ptr_nxt = wr_ptr + LW'(1);
      if (rd_fire) rd_ptr_nxt = rd_ptr + LW'(1);
    end
    level_nxt = wr_ptr_nxt - rd_ptr_nxt;
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
    end
  end

  // High-water mark: hwm_clr restarts tracking from the present occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_level <= '0;
    end else if (flush) begin
      max_level <= '0;
    end else if (hwm_clr) begin
      max_level <= level;
    end else if (level_nxt > max_level) begin
      max_level <= level_nxt;
    end
  end

  fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_mem (
    .clk        (clk),
    .write_en   (wr_fire),
    .write_addr (wr_ptr[AW-1:0]),
    .write_data (write_data),
    .read_addr  (rd_ptr[AW-1:0]),
    .read_data  (head_data)
  );

  generate
    if (FWFT != 0) begin : g_fwft
      assign read_data = head_data;
    end else begin : g_reg
      logic [WIDTH-1:0] read_data_q;

      // Registered mode captures the head on the read handshake and holds it
      // until the next one; a flush leaves it untouched.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          read_data_q <= '0;
        end else if (rd_fire) begin
          read_data_q <= head_data;
        end
      end

      assign read_data = read_data_q;
    end
  endgenerate

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo: DEPTH=4, WIDTH=9, thresholds 2/1.
// dut0 uses registered reads and is driven from a vector table plus a reset
// sequence; dut1 uses first-word-fall-through and is driven by hand.
module tb_stream_fifo;

  localparam int DEPTH = 4;
  localparam int WIDTH = 9;
  localparam int LW    = 3;

  typedef struct {
    logic             flush;
    logic             hwm;
    logic             wv;
    logic [WIDTH-1:0] wd;
    logic             rr;
    logic [LW-1:0]    level;
    logic [LW-1:0]    maxl;
    logic             wr;
    logic             rv;
    logic             af;
    logic             ae;
    logic [WIDTH-1:0] rd;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic             flush0 = 0, hwm_clr0 = 0, wv0 = 0, rr0 = 0;
  logic [WIDTH-1:0] wd0 = '0;
  logic             wr0, rv0, af0, ae0;
  logic [WIDTH-1:0] rd0;
  logic [LW-1:0]    level0, maxl0;

  logic             flush1 = 0, hwm_clr1 = 0, wv1 = 0, rr1 = 0;
  logic [WIDTH-1:0] wd1 = '0;
  logic             wr1, rv1, af1, ae1;
  logic [WIDTH-1:0] rd1;
  logic [LW-1:0]    level1, maxl1;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  stream_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(0), .AFULL_THRESH(2), .AEMPTY_THRESH(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush0), .hwm_clr(hwm_clr0),
    .write_valid(wv0), .write_ready(wr0), .write_data(wd0),
    .read_valid(rv0), .read_ready(rr0), .read_data(rd0),
    .level(level0), .max_level(maxl0), .almost_full(af0), .almost_empty(ae0)
  );

  stream_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(1), .AFULL_THRESH(2), .AEMPTY_THRESH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush1), .hwm_clr(hwm_clr1),
    .write_valid(wv1), .write_ready(wr1), .write_data(wd1),
    .read_valid(rv1), .read_ready(rr1), .read_data(rd1),
    .level(level1), .max_level(maxl1), .almost_full(af1), .almost_empty(ae1)
  );

  function automatic vec_t mk(input logic fl, input logic hw, input logic wv, input logic [WIDTH-1:0] wd,
                              input logic rr, input logic [LW-1:0] lv, input logic [LW-1:0] ml,
                              input logic wr, input logic rv, input logic af, input logic ae,
                              input logic [WIDTH-1:0] rd);
    vec_t v;
    v.flush = fl; v.hwm = hw; v.wv = wv; v.wd = wd; v.rr = rr;
    v.level = lv; v.maxl = ml; v.wr = wr; v.rv = rv; v.af = af; v.ae = ae; v.rd = rd;
    return v;
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one vector on the falling edge, let the rising edge act on it.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    flush0 = v.flush; hwm_clr0 = v.hwm; wv0 = v.wv; wd0 = v.wd; rr0 = v.rr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    string t;
    t = $sformatf("vec%0d", idx);
    check_val({t, ".level"},        32'(level0), 32'(v.level));
    check_val({t, ".max_level"},    32'(maxl0),  32'(v.maxl));
    check_val({t, ".write_ready"},  32'(wr0),    32'(v.wr));
    check_val({t, ".read_valid"},   32'(rv0),    32'(v.rv));
    check_val({t, ".almost_full"},  32'(af0),    32'(v.af));
    check_val({t, ".almost_empty"}, 32'(ae0),    32'(v.ae));
    check_val({t, ".read_data"},    32'(rd0),    32'(v.rd));
  endtask

  task automatic check_reset_state(input string t);
    check_val({t, ".level"},        32'(level0), 32'd0);
    check_val({t, ".max_level"},    32'(maxl0),  32'd0);
    check_val({t, ".write_ready"},  32'(wr0),    32'd1);
    check_val({t, ".read_valid"},   32'(rv0),    32'd0);
    check_val({t, ".almost_full"},  32'(af0),    32'd0);
    check_val({t, ".almost_empty"}, 32'(ae0),    32'd1);
    check_val({t, ".read_data"},    32'(rd0),    32'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] exp_rd;

    // Registered mode: fill, overfill, drain, and full-with-read.
    vecs.push_back(mk(0,0,1,9'h101,0, 1,1,1,1,0,1,9'h000));
    vecs.push_back(mk(0,0,1,9'h0AA,0, 2,2,1,1,1,0,9'h000));
    vecs.push_back(mk(0,0,1,9'h155,0, 3,3,1,1,1,0,9'h000));
    vecs.push_back(mk(0,0,1,9'h1C3,0, 4,4,0,1,1,0,9'h000));
    vecs.push_back(mk(0,0,1,9'h1FF,0, 4,4,0,1,1,0,9'h000));
    vecs.push_back(mk(0,0,1,9'h1FF,1, 3,4,1,1,1,0,9'h101));
    vecs.push_back(mk(0,0,0,9'h000,0, 3,4,1,1,1,0,9'h101));
    vecs.push_back(mk(0,0,0,9'h000,1, 2,4,1,1,1,0,9'h0AA));
    vecs.push_back(mk(0,0,0,9'h000,0, 2,4,1,1,1,0,9'h0AA));
    vecs.push_back(mk(0,0,0,9'h000,1, 1,4,1,1,0,1,9'h155));
    vecs.push_back(mk(0,0,0,9'h000,1, 0,4,1,0,0,1,9'h1C3));
    vecs.push_back(mk(0,0,0,9'h000,1, 0,4,1,0,0,1,9'h1C3));
    // Level 2 streaming across pointer wrap.
    vecs.push_back(mk(0,0,1,9'h011,0, 1,4,1,1,0,1,9'h1C3));
    vecs.push_back(mk(0,0,1,9'h022,0, 2,4,1,1,1,0,9'h1C3));
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      exp_rd = 9'h011;
      else if (i == 1) exp_rd = 9'h022;
      else             exp_rd = 9'(9'h030 + i - 2);
      vecs.push_back(mk(0,0,1,9'(9'h030 + i),1, 2,4,1,1,1,0,exp_rd));
    end
    // Flush with a write, then high-water-mark clear.
    vecs.push_back(mk(0,0,1,9'h040,0, 3,4,1,1,1,0,9'h037));
    vecs.push_back(mk(1,0,1,9'h0EE,0, 0,0,1,0,0,1,9'h037));
    vecs.push_back(mk(0,0,1,9'h05A,0, 1,1,1,1,0,1,9'h037));
    vecs.push_back(mk(0,0,1,9'h05B,0, 2,2,1,1,1,0,9'h037));
    vecs.push_back(mk(0,0,0,9'h000,1, 1,2,1,1,0,1,9'h05A));
    vecs.push_back(mk(0,1,0,9'h000,0, 1,1,1,1,0,1,9'h05A));
    vecs.push_back(mk(0,1,1,9'h066,0, 2,1,1,1,1,0,9'h05A));
    vecs.push_back(mk(0,0,0,9'h000,0, 2,2,1,1,1,0,9'h05A));
    vecs.push_back(mk(1,1,0,9'h000,1, 0,0,1,0,0,1,9'h05A));

    repeat (2) @(negedge clk);
    check_reset_state("reset");
    check_val("reset.fwft_read_valid", 32'(rv1), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end
    @(negedge clk);
    flush0 = 0; hwm_clr0 = 0; wv0 = 0; rr0 = 0;

    // FWFT: a write into an empty FIFO appears only after the edge.
    wv1 = 1; wd1 = 9'h033;
    #1 check_val("fwft.no_bypass", 32'(rv1), 32'd0);
    @(posedge clk); #1;
    check_val("fwft.valid_after_write", 32'(rv1),    32'd1);
    check_val("fwft.head_data",         32'(rd1),    32'h033);
    check_val("fwft.level1",            32'(level1), 32'd1);
    @(negedge clk); wv1 = 0;
    @(posedge clk); #1;
    check_val("fwft.head_held", 32'(rd1), 32'h033);
    @(negedge clk); rr1 = 1;
    @(posedge clk); #1;
    check_val("fwft.level_after_read", 32'(level1), 32'd0);
    check_val("fwft.empty_valid",      32'(rv1),    32'd0);
    @(negedge clk); rr1 = 0; wv1 = 1; wd1 = 9'h044;
    @(negedge clk); wd1 = 9'h055;
    @(negedge clk); wv1 = 0;
    check_val("fwft.level2", 32'(level1), 32'd2);
    check_val("fwft.head44", 32'(rd1),    32'h044);
    rr1 = 1;
    @(posedge clk); #1;
    check_val("fwft.head55", 32'(rd1),    32'h055);
    check_val("fwft.level1b", 32'(level1), 32'd1);
    @(negedge clk); rr1 = 0;

    // Asynchronous reset in the middle of a write burst.
    wv0 = 1; wd0 = 9'h111;
    @(negedge clk); wd0 = 9'h122;
    @(negedge clk); wd0 = 9'h133;
    check_val("burst.level_before_reset", 32'(level0), 32'd2);
    #2 rst_n = 1'b0;
    #1 check_reset_state("async_reset");
    @(negedge clk); wv0 = 0;
    @(negedge clk); rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
